// File: rtl/led_dbg_pkg.sv
// led_dbg_pkg: shared LED debug mode encoding and default timing constants
package led_dbg_pkg;
  typedef enum logic [1:0] {LED_PASS, LED_STRETCH, LED_TOGGLE, LED_HEARTBEAT} led_mode_e;
  localparam int LED_STRETCH_CYC_DFLT = 1_000_000;
  localparam int LED_HB_HALF_CYC_DFLT = 10_000_000;
endpackage

// File: rtl/bit_synchronizer.sv
// bit_synchronizer: multi-flop synchroniser for a single asynchronous bit
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ff <= '0;
    else ff <= {ff[STAGES-2:0], d};
  assign q = ff[STAGES-1];
endmodule

// File: rtl/led_activity_stretcher.sv
// led_activity_stretcher: makes short debug pulses visible on an LED and counts them
module led_activity_stretcher
  import led_dbg_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int STRETCH_CYC = LED_STRETCH_CYC_DFLT,
  parameter int HB_HALF_CYC = LED_HB_HALF_CYC_DFLT,
  parameter int CNT_W = 16
) (
  input  logic             clk_20mhz,
  input  logic             rst_n_20mhz,
  input  logic             led_raw,
  input  logic [1:0]       led_mode,
  input  logic             cnt_clear,
  output logic             led_out,
  output logic             stretch_active,
  output logic [CNT_W-1:0] event_cnt,
  output logic             event_ovf
);
  localparam int SW = $clog2(STRETCH_CYC + 1);
  localparam int HW = (HB_HALF_CYC > 1) ? $clog2(HB_HALF_CYC) : 1;
  localparam logic [SW-1:0] S_LOAD = SW'(STRETCH_CYC);
  localparam logic [HW-1:0] HB_LAST = HW'(HB_HALF_CYC - 1);
  logic s, s_d, rise, chg, go, timed, hb_hold, hb_wrap, ph, ph_nxt, tog, tog_nxt, led_nxt;
  led_mode_e mode_q, mode_d;
  logic [SW-1:0] tmr, tmr_nxt;
  logic [HW-1:0] hb_cnt, hb_nxt;
  bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync (
    .clk(clk_20mhz), .rst_n(rst_n_20mhz), .d(led_raw), .q(s)
  );
  // a mode change blanks shaping for one cycle; the heartbeat is held in reset while stretching
  always_comb begin
    rise = s & ~s_d;
    chg = mode_q != mode_d;
    go = rise & ~chg;
    timed = mode_q == LED_STRETCH || mode_q == LED_HEARTBEAT;
    tmr_nxt = chg ? '0 : (go && timed) ? S_LOAD : (tmr != '0) ? tmr - 1'b1 : tmr;
    hb_hold = chg || mode_q != LED_HEARTBEAT || go || tmr != '0;
    hb_wrap = hb_cnt == HB_LAST;
    hb_nxt = (hb_hold || hb_wrap) ? '0 : hb_cnt + 1'b1;
    ph_nxt = ~hb_hold & (ph ^ hb_wrap);
    tog_nxt = ~chg & (tog ^ (go && mode_q == LED_TOGGLE));
    led_nxt = chg ? 1'b0 : (mode_q == LED_PASS) ? s : (mode_q == LED_TOGGLE) ? tog_nxt
            : go || tmr > SW'(1) || ph_nxt;
    stretch_active = timed && tmr != '0;
  end
  always_ff @(posedge clk_20mhz or negedge rst_n_20mhz)
    if (!rst_n_20mhz) begin
      s_d <= 1'b0;
      mode_q <= LED_PASS;
      mode_d <= LED_PASS;
      tmr <= '0;
      hb_cnt <= '0;
      ph <= 1'b0;
      tog <= 1'b0;
      led_out <= 1'b0;
      event_cnt <= '0;
      event_ovf <= 1'b0;
    end else begin
      s_d <= s;
      mode_q <= led_mode_e'(led_mode);
      mode_d <= mode_q;
      tmr <= tmr_nxt;
      hb_cnt <= hb_nxt;
      ph <= ph_nxt;
      tog <= tog_nxt;
      led_out <= led_nxt;
      if (cnt_clear) begin
        event_cnt <= '0;
        event_ovf <= 1'b0;
      end else if (rise) begin
        if (&event_cnt) event_ovf <= 1'b1;
        else event_cnt <= event_cnt + 1'b1;
      end
    end
endmodule

// File: tb/tb_led_activity_stretcher.sv
// tb_led_activity_stretcher: directed checks of LED shaping modes and event counter
module tb_led_activity_stretcher;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic led_raw = 1'b0;
  logic [1:0] led_mode = 2'd0;
  logic cnt_clear = 1'b0;
  logic led_out, stretch_active, event_ovf;
  logic [3:0] event_cnt;
  int pass_cnt = 0;
  int total = 0;
  logic [63:0] l, a, e;
  led_activity_stretcher #(
    .SYNC_STAGES(2), .STRETCH_CYC(10), .HB_HALF_CYC(20), .CNT_W(4)
  ) dut (
    .clk_20mhz(clk), .rst_n_20mhz(rst_n), .led_raw(led_raw), .led_mode(led_mode),
    .cnt_clear(cnt_clear), .led_out(led_out), .stretch_active(stretch_active),
    .event_cnt(event_cnt), .event_ovf(event_ovf)
  );
  always #25 clk = ~clk;
  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  // step k samples cycle k and drives led_raw = p[k] for that cycle
  task automatic run(input int n, input logic [63:0] p, output logic [63:0] lo, output logic [63:0] ao);
    lo = '0;
    ao = '0;
    for (int k = 0; k < n; k++) begin
      lo[k] = led_out;
      ao[k] = stretch_active;
      led_raw = p[k];
      @(negedge clk);
    end
    led_raw = 1'b0;
  endtask
  task automatic set_mode(input logic [1:0] m);
    led_mode = m;
    repeat (4) @(negedge clk);
  endtask
  task automatic clr();
    cnt_clear = 1'b1;
    @(negedge clk);
    cnt_clear = 1'b0;
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({led_out, stretch_active, event_cnt, event_ovf} !== 7'd0)
      $display("FAIL reset_outputs got=%b exp=0", {led_out, stretch_active, event_cnt, event_ovf});
    else pass_cnt++;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({led_out, event_cnt} !== 5'd0) $display("FAIL reset_release got=%b exp=0", {led_out, event_cnt});
    else pass_cnt++;
  endtask
  task automatic test_pass();
    set_mode(2'd0);
    clr();
    run(10, 64'h1, l, a);
    total++;
    if (l !== 64'h8) $display("FAIL pass_led got=%h exp=%h", l, 64'h8);
    else pass_cnt++;
    total++;
    if (event_cnt !== 4'd1) $display("FAIL pass_cnt got=%0d exp=1", event_cnt);
    else pass_cnt++;
  endtask
  task automatic test_stretch();
    set_mode(2'd1);
    clr();
    run(16, 64'h1, l, a);
    total++;
    if (l !== 64'h1FF8) $display("FAIL stretch_led got=%h exp=%h", l, 64'h1FF8);
    else pass_cnt++;
    total++;
    if (a !== 64'h1FF8) $display("FAIL stretch_active got=%h exp=%h", a, 64'h1FF8);
    else pass_cnt++;
    clr();
    run(24, 64'h21, l, a);
    total++;
    if (l !== 64'h3FFF8) $display("FAIL stretch_retrig got=%h exp=%h", l, 64'h3FFF8);
    else pass_cnt++;
    total++;
    if (event_cnt !== 4'd2) $display("FAIL stretch_cnt got=%0d exp=2", event_cnt);
    else pass_cnt++;
    run(28, 64'h401, l, a);
    total++;
    if (l !== 64'h7FFFF8) $display("FAIL stretch_expiry_reload got=%h exp=%h", l, 64'h7FFFF8);
    else pass_cnt++;
  endtask
  task automatic test_toggle();
    set_mode(2'd2);
    clr();
    run(24, 64'h8421, l, a);
    total++;
    if (l !== 64'h3E0F8) $display("FAIL toggle_led got=%h exp=%h", l, 64'h3E0F8);
    else pass_cnt++;
    total++;
    if (a !== 64'h0) $display("FAIL toggle_active got=%h exp=0", a);
    else pass_cnt++;
    total++;
    if (event_cnt !== 4'd4) $display("FAIL toggle_cnt got=%0d exp=4", event_cnt);
    else pass_cnt++;
  endtask
  task automatic test_heartbeat();
    set_mode(2'd3);
    run(64, 64'h0, l, a);
    for (int k = 0; k < 64; k++) e[k] = (((k + 2) / 20) % 2) == 1;
    total++;
    if (l !== e) $display("FAIL hb_idle got=%h exp=%h", l, e);
    else pass_cnt++;
    run(40, 64'h1, l, a);
    for (int k = 0; k < 64; k++) e[k] = k < 40 && (k <= 12 || k >= 33);
    total++;
    if (l !== e) $display("FAIL hb_activity got=%h exp=%h", l, e);
    else pass_cnt++;
    for (int k = 0; k < 64; k++) e[k] = k >= 3 && k <= 12;
    total++;
    if (a !== e) $display("FAIL hb_active got=%h exp=%h", a, e);
    else pass_cnt++;
  endtask
  task automatic test_counter();
    set_mode(2'd0);
    clr();
    run(34, 64'h1555_5555, l, a);
    total++;
    if ({event_cnt, event_ovf} !== {4'd15, 1'b0})
      $display("FAIL cnt_saturate got=%0d/%b exp=15/0", event_cnt, event_ovf);
    else pass_cnt++;
    run(6, 64'h1, l, a);
    total++;
    if ({event_cnt, event_ovf} !== {4'd15, 1'b1})
      $display("FAIL cnt_overflow got=%0d/%b exp=15/1", event_cnt, event_ovf);
    else pass_cnt++;
    led_raw = 1'b1;
    @(negedge clk);
    led_raw = 1'b0;
    @(negedge clk);
    cnt_clear = 1'b1;
    @(negedge clk);
    cnt_clear = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({event_cnt, event_ovf} !== 5'd0)
      $display("FAIL cnt_clear_priority got=%0d/%b exp=0/0", event_cnt, event_ovf);
    else pass_cnt++;
  endtask
  task automatic test_mode_change();
    set_mode(2'd1);
    run(6, 64'h1, l, a);
    led_mode = 2'd2;
    @(negedge clk);
    total++;
    if (led_out !== 1'b1) $display("FAIL mode_chg_hold got=%b exp=1", led_out);
    else pass_cnt++;
    @(negedge clk);
    total++;
    if ({led_out, stretch_active} !== 2'b00) $display("FAIL mode_chg_blank got=%b exp=00", {led_out, stretch_active});
    else pass_cnt++;
    repeat (3) @(negedge clk);
  endtask
  task automatic test_async_reset();
    set_mode(2'd1);
    clr();
    run(6, 64'h1, l, a);
    total++;
    if (led_out !== 1'b1) $display("FAIL rst_pre_stretch got=%b exp=1", led_out);
    else pass_cnt++;
    #5 rst_n = 1'b0;
    #1;
    total++;
    if (led_out !== 1'b0) $display("FAIL rst_async_drop got=%b exp=0", led_out);
    else pass_cnt++;
    led_raw = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({led_out, stretch_active, event_cnt, event_ovf} !== 7'd0)
      $display("FAIL rst_release_zero got=%b exp=0", {led_out, stretch_active, event_cnt, event_ovf});
    else pass_cnt++;
    repeat (2) @(negedge clk);
    total++;
    if ({led_out, event_cnt} !== {1'b1, 4'd1})
      $display("FAIL rst_release_edge got=%b/%0d exp=1/1", led_out, event_cnt);
    else pass_cnt++;
    led_raw = 1'b0;
  endtask
  initial begin
    test_reset();
    test_pass();
    test_stretch();
    test_toggle();
    test_heartbeat();
    test_counter();
    test_mode_change();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/led_activity_stretcher.md
Name: led_activity_stretcher

Overview:
- Output stage between the debug/LED select mux (its STATE_LED1 output) and the STATE_LED1 board pin.
- The mux output is often a 50 ns pulse or a fast clock, which is invisible on an LED.
- This block synchronises the selected signal, detects rising edges, and shapes the LED drive in a run-time selectable mode: pass-through, pulse stretch, toggle, or heartbeat-with-activity.
- It also keeps a saturating event counter for register readback.

Parameters:
- SYNC_STAGES, 2: synchroniser depth on led_raw. Legal range is 2..4.
- STRETCH_CYC, 1_000_000: LED on-time per event in clk_20mhz cycles (50 ms). Must be ≥1.
- HB_HALF_CYC, 10_000_000: heartbeat half-period in cycles (0.5 s). Must be ≥1.
- CNT_W, 16: event counter width.

Ports:
- clk_20mhz  in  1  system 20 MHz clock; the only clock.
- rst_n_20mhz  in  1  asynchronous, active-low reset.
- led_raw  in  1  selected debug signal from the LED select mux; may be asynchronous.
- led_mode  in  2  0=PASS, 1=STRETCH, 2=TOGGLE, 3=HEARTBEAT; quasi-static register field.
- cnt_clear  in  1  single-cycle pulse; clears event_cnt and event_ovf.
- led_out  out  1  registered LED drive to the pin.
- stretch_active  out  1  high while the stretch timer is nonzero.
- event_cnt  out  CNT_W  saturating count of led_raw rising edges.
- event_ovf  out  1  sticky flag: an edge arrived while event_cnt was saturated.

Behaviour:
- Reset (asynchronous assert, synchronous release): all flops go to 0.
  - This covers the sync chain, edge register, mode register, stretch timer, heartbeat timer/phase, toggle bit, and counter.
  - Outputs at reset: led_out=0, stretch_active=0, event_cnt=0, event_ovf=0.
  - If led_raw is high at reset release, it is counted as one rising edge.
- Synchroniser: led_raw passes through SYNC_STAGES flops to give s.
  - Edge flop: s_d <= s. Rising edge pulse: rise = s & ~s_d.
  - Fixed latency: led_raw sampled at clock N → rise at N+SYNC_STAGES → led_out registered at N+SYNC_STAGES+1. This is 3 cycles with defaults.
- Mode register: mode_q <= led_mode every cycle.
  - When mode_q changes, the next cycle clears the stretch timer, heartbeat timer/phase and toggle bit, and forces led_out=0.
  - A rise arriving in the change cycle is counted but ignored for shaping.
- PASS mode: led_out <= s.
- STRETCH mode:
  - On rise, the timer loads STRETCH_CYC and led_out <= 1. led_out stays high while timer>0; the timer decrements each cycle.
  - led_out is high for exactly STRETCH_CYC cycles after the last rise.
  - A rise while the timer is nonzero reloads the timer (retrigger), so the output extends and there is no gap.
  - A rise on the same cycle the timer reaches 0 also reloads, again with no low gap.
- TOGGLE mode: the toggle bit flips on each rise, and led_out <= toggle bit.
- HEARTBEAT mode:
  - With no activity, the heartbeat timer counts HB_HALF_CYC cycles per phase, and led_out follows the phase bit (low first after reset or mode entry).
  - A rise runs the stretch timer exactly as in STRETCH mode and forces led_out=1.
  - When the stretch timer expires, the heartbeat timer and phase restart at 0 (low), so the LED is low for a full HB_HALF_CYC after activity.
- stretch_active = (timer != 0). It is valid in STRETCH and HEARTBEAT modes and is 0 in the other modes.
- Event counter (all modes):
  - Increments on rise and saturates at all-ones.
  - A rise while saturated sets event_ovf; event_ovf stays set until cleared.
  - cnt_clear has priority over a simultaneous rise: the result is cnt=0, ovf=0, and that rise is not counted.
- Timer widths: $clog2(STRETCH_CYC+1) and $clog2(HB_HALF_CYC). Counters never wrap, and all comparisons are unsigned.
- Reset mid-stretch: the LED drops immediately (asynchronously) and no state is retained.

Decomposition:
- Shared package led_dbg_pkg:
  - typedef enum logic [1:0] led_mode_e: LED_PASS, LED_STRETCH, LED_TOGGLE, LED_HEARTBEAT.
  - Default timing constants LED_STRETCH_CYC_DFLT and LED_HB_HALF_CYC_DFLT, so the top level and the register map share them.
- One sub-module, bit_synchronizer:
  - Parameter STAGES; ports clk, async active-low reset, d, q.
  - Reusable for other asynchronous debug inputs.

Test Plan (bench overrides STRETCH_CYC=10, HB_HALF_CYC=20):
1. PASS, a single-cycle led_raw pulse at cycle 100 → led_out high only in cycle 103; event_cnt=1.
2. STRETCH, a 1-cycle pulse at cycle 100 → led_out high cycles 103..112 (10 cycles), stretch_active has the same window. A second pulse at cycle 105 → high through cycle 117 with no gap; event_cnt=2.
3. TOGGLE, four pulses spaced 5 cycles apart → led_out sequence 1,0,1,0, each transition 3 cycles after its pulse; event_cnt=4.
4. HEARTBEAT, idle → led_out low 20 cycles / high 20 cycles, repeating. A pulse arriving during the high phase → high for 10 cycles from pulse+3, then low for exactly 20 cycles.
5. Counter with CNT_W=4: 15 pulses → cnt=15, ovf=0. 16th pulse → cnt=15, ovf=1. cnt_clear coincident with a rise → cnt=0, ovf=0.
6. STRETCH mid-stretch: switch led_mode to TOGGLE → led_out=0 two cycles later. Assert rst_n_20mhz low during a stretch → led_out=0 asynchronously, and all outputs read 0 after release.
